// File: rtl/rgb565_grayscale_pipe_ise.sv
// rgb565_grayscale_pipe_ise: pipelined four-lane RGB565 -> 8-bit luma custom instruction
// with run-time programmable coefficients, gray/binary output mode and threshold.
module rgb565_grayscale_pipe_ise #(
    parameter logic [7:0]  customInstructionId = 8'd13,
    parameter int unsigned PIPELINE            = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic        ciDone,
    output logic [31:0] ciResult
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [7:0] DEF_R = 8'd77, DEF_G = 8'd150, DEF_B = 8'd29, DEF_THR = 8'h80;
    localparam logic [1:0] CNT_INIT = (PIPELINE >= 2) ? 2'(PIPELINE - 2) : 2'd0;
    // Only s[17:8] matters downstream, so the sum is carried as 10 bits.
    function automatic logic [9:0] lane_sum(input logic [15:0] p, input logic [7:0] cr, cg, cb);
        logic [4:0] r, b;
        logic [5:0] g;
        r = p[7:3];
        g = {p[2:0], p[15:13]};
        b = p[12:8];
        return 10'((18'({r, r[4:2]}) * 18'(cr) + 18'({g, g[5:4]}) * 18'(cg)
                  + 18'({b, b[4:2]}) * 18'(cb)) >> 8);
    endfunction
    function automatic logic [7:0] lane_out(input logic [9:0] s, input logic bin, input logic [7:0] thr);
        logic [7:0] y;
        y = (|s[9:8]) ? 8'hFF : s[7:0];
        return bin ? ((y >= thr) ? 8'hFF : 8'h00) : y;
    endfunction
    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] res_q, res_d;
    logic [7:0]  coef_r_q, coef_r_d, coef_g_q, coef_g_d, coef_b_q, coef_b_d, thr_q, thr_d;
    logic        mode_q, mode_d;
    logic [63:0] pix_q, pix_d;
    logic [7:0]  scr_q, scr_d, scg_q, scg_d, scb_q, scb_d, sthr_q, sthr_d;
    logic        smode_q, smode_d;
    logic [3:0][9:0] sum_q, sum_d, sum_in, sum_op;
    logic [31:0] y_in, y_op, y_sum, cfg_rd;
    logic [63:0] pix_in;
    logic        hit_cvt, hit_cfg, idle_start;
    assign pix_in     = {ciValueB, ciValueA};
    assign hit_cvt    = ciN == customInstructionId;
    assign hit_cfg    = ciN == customInstructionId + 8'd1;
    assign idle_start = ciStart && state_q == IDLE;
    assign cfg_rd     = {mode_q, thr_q[6:0], coef_r_q, coef_g_q, coef_b_q};
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign sum_in[i]        = lane_sum(pix_in[16*i +: 16], coef_r_q, coef_g_q, coef_b_q);
        assign sum_op[i]        = lane_sum(pix_q[16*i +: 16], scr_q, scg_q, scb_q);
        assign y_in[8*i +: 8]   = lane_out(sum_in[i], mode_q, thr_q);
        assign y_op[8*i +: 8]   = lane_out(sum_op[i], smode_q, sthr_q);
        assign y_sum[8*i +: 8]  = lane_out(sum_q[i], smode_q, sthr_q);
    end
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        res_d    = 32'd0;
        coef_r_d = coef_r_q;
        coef_g_d = coef_g_q;
        coef_b_d = coef_b_q;
        thr_d    = thr_q;
        mode_d   = mode_q;
        pix_d    = pix_q;
        scr_d    = scr_q;
        scg_d    = scg_q;
        scb_d    = scb_q;
        sthr_d   = sthr_q;
        smode_d  = smode_q;
        sum_d    = sum_q;
        if (ciCke) begin
            if (idle_start && hit_cfg) begin
                state_d = DONE;
                done_d  = 1'b1;
                if (ciValueA[1:0] == 2'd0) begin
                    coef_r_d = ciValueB[23:16];
                    coef_g_d = ciValueB[15:8];
                    coef_b_d = ciValueB[7:0];
                end else if (ciValueA[1:0] == 2'd1) begin
                    thr_d  = ciValueB[7:0];
                    mode_d = ciValueB[8];
                end else if (ciValueA[1:0] == 2'd2) begin
                    res_d = cfg_rd;
                end else begin
                    coef_r_d = DEF_R;
                    coef_g_d = DEF_G;
                    coef_b_d = DEF_B;
                    thr_d    = DEF_THR;
                    mode_d   = 1'b0;
                end
            end else if (idle_start && hit_cvt) begin
                // Snapshot config so later writes cannot disturb this conversion.
                pix_d   = pix_in;
                scr_d   = coef_r_q;
                scg_d   = coef_g_q;
                scb_d   = coef_b_q;
                sthr_d  = thr_q;
                smode_d = mode_q;
                state_d = (PIPELINE <= 1) ? DONE : BUSY;
                done_d  = PIPELINE <= 1;
                res_d   = (PIPELINE <= 1) ? y_in : 32'd0;
                cnt_d   = CNT_INIT;
            end else if (state_q == BUSY) begin
                state_d = (cnt_q == 2'd0) ? DONE : BUSY;
                done_d  = cnt_q == 2'd0;
                res_d   = (cnt_q != 2'd0) ? 32'd0 : (PIPELINE >= 3) ? y_sum : y_op;
                cnt_d   = (cnt_q == 2'd0) ? cnt_q : cnt_q - 2'd1;
                sum_d   = sum_op;
            end else if (state_q == DONE) begin
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            done_q   <= 1'b0;
            res_q    <= 32'd0;
            coef_r_q <= DEF_R;
            coef_g_q <= DEF_G;
            coef_b_q <= DEF_B;
            thr_q    <= DEF_THR;
            mode_q   <= 1'b0;
            pix_q    <= 64'd0;
            scr_q    <= 8'd0;
            scg_q    <= 8'd0;
            scb_q    <= 8'd0;
            sthr_q   <= 8'd0;
            smode_q  <= 1'b0;
            sum_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            res_q    <= res_d;
            coef_r_q <= coef_r_d;
            coef_g_q <= coef_g_d;
            coef_b_q <= coef_b_d;
            thr_q    <= thr_d;
            mode_q   <= mode_d;
            pix_q    <= pix_d;
            scr_q    <= scr_d;
            scg_q    <= scg_d;
            scb_q    <= scb_d;
            sthr_q   <= sthr_d;
            smode_q  <= smode_d;
            sum_q    <= sum_d;
        end
    end
    assign ciDone   = done_q;
    assign ciResult = res_q;
endmodule

// File: tb/tb_rgb565_grayscale_pipe_ise.sv
// tb_rgb565_grayscale_pipe_ise: directed and randomized checks of the grayscale ISE
// using an expected-result queue and an independent integer reference model.
module tb_rgb565_grayscale_pipe_ise;
    localparam int         P  = 2;
    localparam logic [7:0] ID = 8'd13;
    localparam logic [7:0] CF = 8'd14;
    logic        clock = 1'b0, reset = 1'b0, ciStart = 1'b0, ciCke = 1'b1;
    logic [7:0]  ciN = 8'd0;
    logic [31:0] ciValueA = 32'd0, ciValueB = 32'd0;
    logic        ciDone;
    logic [31:0] ciResult;
    int          checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  cr, cg, cb, th;
    logic        md;
    logic [31:0] a, b, e;

    rgb565_grayscale_pipe_ise #(.customInstructionId(ID), .PIPELINE(P)) dut (
        .clock(clock), .reset(reset), .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN),
        .ciValueA(ciValueA), .ciValueB(ciValueB), .ciDone(ciDone), .ciResult(ciResult)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_luma(input int p, input int kr, kg, kb, input bit bin, input int t);
        int r5, g6, b5, s, y;
        r5 = (p >> 3) & 31;
        g6 = ((p & 7) << 3) | ((p >> 13) & 7);
        b5 = (p >> 8) & 31;
        s  = ((r5 << 3) | (r5 >> 2)) * kr + ((g6 << 2) | (g6 >> 4)) * kg + ((b5 << 3) | (b5 >> 2)) * kb;
        y  = (s > 65535) ? 255 : s / 256;
        return 8'(bin ? ((y >= t) ? 255 : 0) : y);
    endfunction

    task automatic op(input string tag, input logic [7:0] n, input logic [31:0] va, vb, exp,
                      input int lat, input int stall);
        int cyc;
        @(negedge clock);
        ciStart = 1'b1; ciN = n; ciValueA = va; ciValueB = vb;
        exp_q.push_back(exp);
        @(negedge clock);
        ciStart = 1'b0;
        cyc = 1;
        if (stall > 0) begin
            ciCke = 1'b0;
            repeat (stall) begin
                @(negedge clock);
                cyc++;
                chk({tag, "_frozen"}, {31'd0, ciDone}, 32'd0);
            end
            ciCke = 1'b1;
        end
        while (!ciDone && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        chk({tag, "_lat"}, cyc, lat);
        chk({tag, "_res"}, ciResult, exp_q.pop_front());
        @(negedge clock);
        chk({tag, "_pulse_done"}, {31'd0, ciDone}, 32'd0);
        chk({tag, "_pulse_res"}, ciResult, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        chk("reset_done", {31'd0, ciDone}, 32'd0);
        chk("reset_res", ciResult, 32'd0);
        reset = 1'b1;
        op("rd_def", CF, 32'd2, 32'd0, 32'h004D961D, 1, 0);
        op("wr_coef", CF, 32'd0, 32'h00102030, 32'd0, 1, 0);
        op("rd_coef", CF, 32'd2, 32'd0, 32'h0010_2030, 1, 0);
        // convert dropped by a reset while in flight
        @(negedge clock);
        ciStart = 1'b1; ciN = ID; ciValueA = 32'hE00700F8; ciValueB = 32'hFFFF1F00;
        @(negedge clock);
        ciStart = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("midrst_done", {31'd0, ciDone}, 32'd0);
            chk("midrst_res", ciResult, 32'd0);
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("dropped_done", {31'd0, ciDone}, 32'd0);
        end
        op("rd_after_rst", CF, 32'd2, 32'd0, 32'h004D961D, 1, 0);
        op("cvt_def", ID, 32'hE00700F8, 32'hFFFF1F00, 32'hFF1C954C, P, 0);
        op("wr_bin", CF, 32'd1, 32'h00000180, 32'd0, 1, 0);
        op("rd_bin", CF, 32'd2, 32'd0, 32'h804D961D, 1, 0);
        op("cvt_bin", ID, 32'hE00700F8, 32'hFFFF1F00, 32'hFF00FF00, P, 0);
        op("wr_gray", CF, 32'd1, 32'h00000080, 32'd0, 1, 0);
        op("wr_sat", CF, 32'd0, 32'h00FFFFFF, 32'd0, 1, 0);
        op("cvt_sat", ID, 32'h00F8FFFF, 32'd0, 32'h0000FEFF, P, 0);
        op("restore", CF, 32'd3, 32'd0, 32'd0, 1, 0);
        op("cvt_stall", ID, 32'hE00700F8, 32'hFFFF1F00, 32'hFF1C954C, P + 3, 3);
        @(negedge clock);
        ciStart = 1'b1; ciN = 8'd47; ciValueA = 32'd0; ciValueB = 32'h00123456;
        repeat (4) begin
            @(negedge clock);
            chk("foreign_done", {31'd0, ciDone}, 32'd0);
            chk("foreign_res", ciResult, 32'd0);
        end
        ciStart = 1'b0;
        op("rd_foreign", CF, 32'd2, 32'd0, 32'h004D961D, 1, 0);
        for (int k = 0; k < 6; k++) begin
            cr = 8'($urandom_range(0, 255));
            cg = 8'($urandom_range(0, 255));
            cb = 8'($urandom_range(0, 255));
            th = 8'($urandom_range(0, 255));
            md = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            op("rnd_coef", CF, 32'd0, {8'd0, cr, cg, cb}, 32'd0, 1, 0);
            op("rnd_mode", CF, 32'd1, {23'd0, md, th}, 32'd0, 1, 0);
            e = {ref_luma(int'(b[31:16]), int'(cr), int'(cg), int'(cb), md, int'(th)),
                 ref_luma(int'(b[15:0]),  int'(cr), int'(cg), int'(cb), md, int'(th)),
                 ref_luma(int'(a[31:16]), int'(cr), int'(cg), int'(cb), md, int'(th)),
                 ref_luma(int'(a[15:0]),  int'(cr), int'(cg), int'(cb), md, int'(th))};
            op("rnd_cvt", ID, a, b, e, P, 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
